// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: 8N1 UART transmitter fed by a small valid/ready FIFO.
// Bytes from the upstream character source queue in the FIFO. The FSM pops
// one byte per frame and shifts it out LSB first. A new frame starts
// back-to-back when a byte is waiting at the end of a stop bit.
module ascii_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = 16;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                tx_q, tx_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [7:0]          mem_q [FIFO_DEPTH];

    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                baud_done;

    // Ready depends on the registered count and on reset only, never on in_valid.
    assign in_ready   = rst_n & (count_q != CNT_FULL);
    assign push       = in_valid & in_ready;
    assign fifo_empty = (count_q == '0);
    assign baud_done  = (baud_q == BAUD_LAST);

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) | ~fifo_empty;
    assign fifo_count = count_q;

    // FIFO storage; contents need no reset because pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Next-state, serializer and FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end

            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (!fifo_empty) begin
                        // Next byte already waiting: start bit follows with no idle gap.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register with synchronous active-low reset; a reset drops any queued bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb_ascii_uart_tx: cycle-accurate checks of ascii_uart_tx against a frame-schedule model.
// The model keeps, per accepted byte, its accept edge and frame start edge;
// tx, busy, fifo_count and in_ready are all derived from that schedule.
module tb_ascii_uart_tx;

    localparam int unsigned C  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 3;
    localparam int          FRAME = 10 * C;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int         acc_e[$];
    int         st_s[$];
    logic [7:0] dat[$];
    int         last_start = -1000000;

    ascii_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bytes sitting in the FIFO after edge t.
    function automatic int model_count(input int t);
        int c = 0;
        foreach (acc_e[i]) if (acc_e[i] <= t && t < st_s[i]) c++;
        return c;
    endfunction

    function automatic logic model_active(input int t);
        foreach (st_s[i]) if (st_s[i] <= t && t < st_s[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    // Line level after edge t: start 0, data LSB first, stop 1, idle 1.
    function automatic logic model_tx(input int t);
        int         k;
        logic [7:0] b;
        foreach (st_s[i]) begin
            if (st_s[i] <= t && t < st_s[i] + FRAME) begin
                k = (t - st_s[i]) / C;
                b = dat[i];
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return b[k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic model_idle(input int t);
        return (model_count(t) == 0) && !model_active(t);
    endfunction

    // One clock: drive inputs, check in_ready, advance model on the edge, check outputs.
    task automatic cycle(input logic rn, input logic v, input logic [7:0] d, output logic acc);
        logic exp_rdy;
        int   s;
        rst_n    = rn;
        in_valid = v;
        in_data  = d;
        #1;
        exp_rdy = rn && (model_count(cyc) < D);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        cyc++;
        if (!rn) begin
            acc_e.delete();
            st_s.delete();
            dat.delete();
            last_start = -1000000;
        end else if (acc) begin
            s = (cyc + 1 > last_start + FRAME) ? cyc + 1 : last_start + FRAME;
            acc_e.push_back(cyc);
            st_s.push_back(s);
            dat.push_back(d);
            last_start = s;
        end
        while (st_s.size() > 0 && st_s[0] + FRAME <= cyc) begin
            void'(acc_e.pop_front());
            void'(st_s.pop_front());
            void'(dat.pop_front());
        end
        @(negedge clk);
        check("tx", 32'(tx), 32'(model_tx(cyc)));
        check("busy", 32'(busy), 32'(!model_idle(cyc)));
        check("fifo_count", 32'(fifo_count), 32'(model_count(cyc)));
    endtask

    task automatic drain();
        logic a;
        int   n = 0;
        while (!model_idle(cyc) && n < 2000) begin
            cycle(1'b1, 1'b0, 8'(($urandom)), a);
            n++;
        end
        if (n >= 2000) check("drain_timeout", 32'(0), 32'(1));
        cycle(1'b1, 1'b0, 8'h00, a);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       a;
        logic       hold_v;
        logic [7:0] hold_d;
        logic       v;
        logic       rn;
        logic [7:0] d;
        logic [7:0] bp_bytes [6];
        int         idx;
        int         ms;
        int         maxc;
        int         guard;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);

        // Reset with in_valid high: nothing enqueued.
        repeat (3) cycle(1'b0, 1'b1, 8'hA5, a);
        cycle(1'b1, 1'b0, 8'hA5, a);
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_count", 32'(fifo_count), 32'(0));
        repeat (3) cycle(1'b1, 1'b0, 8'h00, a);

        // Single byte.
        cycle(1'b1, 1'b1, 8'h54, a);
        drain();

        // Back-to-back frames.
        cycle(1'b1, 1'b1, 8'h41, a);
        cycle(1'b1, 1'b1, 8'h20, a);
        drain();

        // Backpressure with in_valid held high.
        for (int i = 0; i < 6; i++) bp_bytes[i] = 8'(8'h61 + i);
        idx   = 0;
        guard = 0;
        while (idx < 6 && guard < 1000) begin
            cycle(1'b1, 1'b1, bp_bytes[idx], a);
            if (a) idx++;
            guard++;
            if (idx == 5 && guard == 5) begin
                #1;
                check("bp_full_count", 32'(fifo_count), 32'(4));
                check("bp_full_ready", 32'(in_ready), 32'(0));
            end
        end
        if (idx < 6) check("bp_accept_timeout", 32'(idx), 32'(6));
        drain();

        // Reset mid-frame with two bytes queued behind the active one.
        cycle(1'b1, 1'b1, 8'hC3, a);
        ms = last_start;
        cycle(1'b1, 1'b1, 8'h3C, a);
        cycle(1'b1, 1'b1, 8'h99, a);
        while (cyc < ms + 4 * C + 1) cycle(1'b1, 1'b0, 8'h00, a);
        cycle(1'b0, 1'b0, 8'h00, a);
        check("midrst_tx", 32'(tx), 32'(1));
        check("midrst_count", 32'(fifo_count), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        repeat (60) cycle(1'b1, 1'b0, 8'h00, a);

        // Pointer wrap: nine bytes one at a time.
        maxc = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b1, 8'($urandom), a);
            while (!model_idle(cyc)) begin
                if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
                cycle(1'b1, 1'b0, 8'h00, a);
            end
        end
        check("wrap_max_count", 32'(maxc), 32'(1));

        // Randomized traffic with occasional resets; data held while stalled.
        hold_v = 1'b0;
        hold_d = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            rn = ($urandom_range(0, 399) != 0);
            if (hold_v) begin
                v = 1'b1;
                d = hold_d;
            end else begin
                v = ($urandom_range(0, 3) == 0);
                d = 8'($urandom);
            end
            cycle(rn, v, d, a);
            hold_v = rn && v && !a;
            hold_d = d;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ascii_uart_tx.md
# ascii_uart_tx

Serializes the ASCII character stream produced by the on-chip string generator onto a single UART transmit pin using 8N1 framing. It sits directly downstream of the character source and accepts bytes through a valid/ready handshake into a small FIFO, which absorbs the source's one-byte-per-clock bursts. The transmit pin is driven out on a bidirectional IO configured as output at the top level.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, default 4: FIFO entries; power of two, ≥2.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous and active-low. Sampled only on the rising edge of clk.
- in_data  input  8  character byte from the upstream source.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a byte; equals rst_n AND NOT fifo_full (combinational).
- tx  output  1  UART serial output; idle high; registered.
- busy  output  1  high when the FIFO is non-empty or a frame is in progress; registered-state derived.
- fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: on an edge where in_valid AND in_ready, in_data is written at the write pointer; the pointer wraps modulo FIFO_DEPTH.
- Full: in_ready=0 when count==FIFO_DEPTH, even if a pop occurs in the same cycle; no push is ever lost or overwritten.
- Pop: occurs in state IDLE with count>0, or on the last cycle of STOP with count>0. The popped byte loads the shift register; the read pointer wraps modulo FIFO_DEPTH.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0: pop, go to START, tx<=0.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx<=bit0.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index counter 0..7. After bit7, go to STOP with tx<=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. On the last cycle, if count>0, pop and go to START (back-to-back, no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. It resets to 0 on every state or bit change and is at least 16 bits wide.
- busy = (state != IDLE) OR (count != 0).
- Reset (rst_n low at an edge), including mid-frame:
  - state<=IDLE, tx<=1, pointers, count, bit index and baud counter cleared.
  - FIFO contents are discarded; in_ready=0 while rst_n is low.
  - After release: in_ready=1, busy=0, fifo_count=0, tx=1.

## Timing
- Byte accepted at edge E0 into an empty FIFO while IDLE: tx falls at edge E0+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles: start, 8 data bits, 1 stop.
- Back-to-back frames: the next start bit begins at the edge immediately after the last stop cycle, so N queued bytes take N*10*CLKS_PER_BIT cycles.
- in_ready depends on the registered count only; there is no combinational path from in_valid to in_ready.
- The upstream source may assert in_valid every cycle. in_data must be held while in_valid AND NOT in_ready.

## Test plan
- Reset values: assert rst_n low for 3 edges with in_valid=1 -> tx=1, in_ready=0, busy=0, fifo_count=0; no byte enqueued after release.
- Single byte (CLKS_PER_BIT=4): 0x54 accepted at E0 -> tx low from E0+1 for 4 cycles, then data 0,0,1,0,1,0,1,0 (4 cycles each), then high for 4 cycles; busy falls 40 cycles after E0+1.
- Back-to-back frames: 0x41 then 0x20 on consecutive edges -> 80 contiguous frame cycles with no idle gap; the second start bit begins right after the first stop bit.
- Backpressure (FIFO_DEPTH=4): in_valid held high with 6 distinct bytes ->
  - 5 bytes accepted on consecutive edges, because the first is popped immediately;
  - in_ready then low, fifo_count=4;
  - 6th byte accepted at the edge after the first frame's final stop cycle;
  - all 6 bytes transmitted in order.
- Reset mid-frame: rst_n low during DATA bit 3 with 2 bytes queued -> tx=1 at the next edge, fifo_count=0, busy=0; no further frames after release.
- Pointer wrap: push and transmit 9 bytes one at a time -> every byte reproduced correctly across two FIFO wraps; fifo_count never exceeds 1.
